// File: rtl/stbus_frame_tx_if.sv
//==============================================================================
// Module      : stbus_frame_tx_if
// Description : Bundle of the ST-bus transmitter signals: ST-bus timing inputs
//               (c4, f0), host channel-store write port, bank swap request and
//               the transmitter status/serial outputs.
//               master : host / ST-bus environment side (drives c4, f0, writes)
//               slave  : stbus_frame_tx side (drives data_to_dt and status)
//               Macro STBUS_TX_PATTERN_EN adds the pattern_mode signal.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface stbus_frame_tx_if;
    logic       c4;            // ST-bus 4.096 MHz bit clock
    logic       f0;            // ST-bus frame pulse, active low
    logic       wr_en;         // host byte write strobe
    logic [4:0] wr_addr;       // channel number of the write
    logic [7:0] wr_data;       // channel byte
    logic       swap_req;      // commit shadow bank at next frame start
`ifdef STBUS_TX_PATTERN_EN
    logic       pattern_mode;  // transmit channel-number pattern instead of bank data
`endif
    logic       data_to_dt;    // serial ST-bus data
    logic       frame_start;   // one-cycle frame boundary pulse
    logic       locked;        // frame timing acquired
    logic       swap_pending;  // swap requested, not yet applied
    logic       frame_err;     // sticky frame timing error

`ifdef STBUS_TX_PATTERN_EN
    modport master (
        output c4, f0, wr_en, wr_addr, wr_data, swap_req, pattern_mode,
        input  data_to_dt, frame_start, locked, swap_pending, frame_err
    );
    modport slave (
        input  c4, f0, wr_en, wr_addr, wr_data, swap_req, pattern_mode,
        output data_to_dt, frame_start, locked, swap_pending, frame_err
    );
`else
    modport master (
        output c4, f0, wr_en, wr_addr, wr_data, swap_req,
        input  data_to_dt, frame_start, locked, swap_pending, frame_err
    );
    modport slave (
        input  c4, f0, wr_en, wr_addr, wr_data, swap_req,
        output data_to_dt, frame_start, locked, swap_pending, frame_err
    );
`endif
endinterface

`default_nettype wire

// File: rtl/stbus_frame_tx.sv
//==============================================================================
// Module      : stbus_frame_tx
// Description : ST-bus serial transmitter toward the DT side. Runs on clk50,
//               recovers frame timing from asynchronous c4 / f0 and shifts out
//               one 256-bit frame (32 channels x 8 bits, MSB first, each bit
//               held for two c4 periods) per f0. Channel bytes come from a
//               double-buffered 32x8 store; the host writes the shadow bank
//               and the banks swap only on a frame boundary.
// Ports       : clk50        - 50 MHz system clock (only clock)
//               reset_out_rg - asynchronous active-high reset
//               bus          - stbus_frame_tx_if.slave (c4, f0, host write
//                              port, swap_req, data_to_dt, frame_start,
//                              locked, swap_pending, frame_err)
// Options     : define STBUS_TX_PATTERN_EN to add bus.pattern_mode; when set,
//               every channel sends its channel number XOR 0xA5.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module stbus_frame_tx #(
    parameter int CH_NUM      = 32,   // channels per frame (address is 5 bits)
    parameter int SYNC_STAGES = 2     // synchronizer depth, 2 or 3
) (
    input  logic              clk50,
    input  logic              reset_out_rg,
    stbus_frame_tx_if.slave   bus
);

    localparam logic [8:0] C_POS_LAST = 9'd511;
    localparam logic [7:0] C_PATTERN  = 8'hA5;

    // Synchronizers and edge strobes
    logic [SYNC_STAGES-1:0] r_c4_sync;
    logic [SYNC_STAGES-1:0] r_f0_sync;
    logic                   r_c4_d;
    logic                   r_f0_d;
    logic                   r_c4_rise;
    logic                   r_c4_fall;

    // Frame timing and transmit state
    logic [8:0]             r_pos;
    logic                   r_locked;
    logic                   r_frame_start;
    logic                   r_frame_err;
    logic                   r_data;
    logic                   r_bank_sel;
    logic                   r_swap_pending;

    // Double-buffered channel store, intentionally without reset
    logic [7:0]             r_bank [2][CH_NUM];

    logic [4:0]             w_channel;
    logic [2:0]             w_bit_idx;
    logic [7:0]             w_bank_byte;
    logic [7:0]             w_tx_byte;

    //--------------------------------------------------------------------------
    // c4 / f0 synchronizers. r_f0_d is delayed by the same extra register as
    // the strobes so f0 is sampled in step with the c4 rise it accompanies.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk50 or posedge reset_out_rg) begin
        if (reset_out_rg) begin
            r_c4_sync <= '0;
            r_f0_sync <= '1;
            r_c4_d    <= 1'b0;
            r_f0_d    <= 1'b1;
            r_c4_rise <= 1'b0;
            r_c4_fall <= 1'b0;
        end else begin
            r_c4_sync <= {r_c4_sync[SYNC_STAGES-2:0], bus.c4};
            r_f0_sync <= {r_f0_sync[SYNC_STAGES-2:0], bus.f0};
            r_c4_d    <= r_c4_sync[SYNC_STAGES-1];
            r_f0_d    <= r_f0_sync[SYNC_STAGES-1];
            r_c4_rise <=  r_c4_sync[SYNC_STAGES-1] & ~r_c4_d;
            r_c4_fall <= ~r_c4_sync[SYNC_STAGES-1] &  r_c4_d;
        end
    end

    //--------------------------------------------------------------------------
    // Frame position tracking. f0 always realigns pos; while locked, f0 away
    // from pos 511 or a wrap without f0 marks a sticky error, and a missing
    // f0 additionally drops lock until the next f0.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk50 or posedge reset_out_rg) begin
        if (reset_out_rg) begin
            r_pos         <= '0;
            r_locked      <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (r_c4_rise) begin
                if (!r_f0_d) begin
                    if (r_locked && (r_pos != C_POS_LAST)) begin
                        r_frame_err <= 1'b1;
                    end
                    r_pos         <= '0;
                    r_frame_start <= 1'b1;
                    r_locked      <= 1'b1;
                end else begin
                    if (r_locked && (r_pos == C_POS_LAST)) begin
                        r_frame_err <= 1'b1;
                        r_locked    <= 1'b0;
                    end
                    r_pos <= r_pos + 9'd1;
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Bank selection. A request arriving in the same cycle as frame_start is
    // kept pending for the following frame (later assignment wins).
    //--------------------------------------------------------------------------
    always_ff @(posedge clk50 or posedge reset_out_rg) begin
        if (reset_out_rg) begin
            r_bank_sel     <= 1'b0;
            r_swap_pending <= 1'b0;
        end else begin
            if (r_frame_start && r_swap_pending) begin
                r_bank_sel     <= ~r_bank_sel;
                r_swap_pending <= 1'b0;
            end
            if (bus.swap_req) begin
                r_swap_pending <= 1'b1;
            end
        end
    end

    // Host writes always land in the inactive (shadow) bank
    always_ff @(posedge clk50) begin
        if (bus.wr_en) begin
            r_bank[~r_bank_sel][bus.wr_addr] <= bus.wr_data;
        end
    end

    //--------------------------------------------------------------------------
    // Serializer: channel = pos[8:4], bit = 7 - pos[3:1]
    //--------------------------------------------------------------------------
    always_comb begin
        w_channel   = r_pos[8:4];
        w_bit_idx   = 3'd7 - r_pos[3:1];
        w_bank_byte = r_bank[r_bank_sel][w_channel];
`ifdef STBUS_TX_PATTERN_EN
        w_tx_byte   = bus.pattern_mode ? ({3'b000, w_channel} ^ C_PATTERN) : w_bank_byte;
`else
        w_tx_byte   = w_bank_byte;
`endif
    end

    // Line idles high whenever frame timing is not held
    always_ff @(posedge clk50 or posedge reset_out_rg) begin
        if (reset_out_rg) begin
            r_data <= 1'b1;
        end else if (!r_locked) begin
            r_data <= 1'b1;
        end else if (r_c4_fall) begin
            r_data <= w_tx_byte[w_bit_idx];
        end
    end

    assign bus.data_to_dt   = r_data;
    assign bus.frame_start  = r_frame_start;
    assign bus.locked       = r_locked;
    assign bus.swap_pending = r_swap_pending;
    assign bus.frame_err    = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_stbus_frame_tx.sv
//==============================================================================
// Module      : tb_stbus_frame_tx
// Description : Directed self-checking bench for stbus_frame_tx. c4 toggles
//               every 122 ns; f0 is driven low for one c4 period straddling
//               the rise that starts a frame. data_to_dt is captured just
//               after every c4 rise, so sample k of a frame holds the bit for
//               position k-1.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_stbus_frame_tx;

    logic clk50 = 1'b0;
    logic rst   = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   fs_cnt = 0;
    logic cap [512];
    logic snap_pend;
    logic snap_locked;

    stbus_frame_tx_if bus();

    stbus_frame_tx #(.CH_NUM(32), .SYNC_STAGES(2)) dut (
        .clk50        (clk50),
        .reset_out_rg (rst),
        .bus          (bus)
    );

    always #10 clk50 = ~clk50;

    initial begin
        bus.c4 = 1'b0;
        #1;
        forever #122 bus.c4 = ~bus.c4;
    end

    always @(negedge clk50) if (bus.frame_start === 1'b1) fs_cnt++;

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic write_byte(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk50);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        @(negedge clk50);
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_swap();
        @(negedge clk50);
        bus.swap_req = 1'b1;
        @(negedge clk50);
        bus.swap_req = 1'b0;
    endtask

    // One frame: optional f0 at R0, then nrises sampled rises. Host action at sample 100.
    task automatic send_frame(input bit with_f0, input int action, input int nrises);
        @(negedge bus.c4);
        bus.f0 = with_f0 ? 1'b0 : 1'b1;
        @(posedge bus.c4);
        @(negedge bus.c4);
        bus.f0 = 1'b1;
        for (int k = 1; k <= nrises; k++) begin
            @(posedge bus.c4);
            #1;
            cap[k-1] = bus.data_to_dt;
            if (k == 1) begin
                snap_pend   = bus.swap_pending;
                snap_locked = bus.locked;
            end
            if (k == 100 && action == 1) begin
                write_byte(5'd0,  8'h81);
                write_byte(5'd31, 8'h3C);
                write_byte(5'd5,  8'h5A);
                pulse_swap();
            end
            if (k == 100 && action == 2) begin
                write_byte(5'd5, 8'hFF);
            end
        end
    endtask

    function automatic logic [7:0] get_byte(input int ch);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = cap[ch*16 + 2*i];
        return b;
    endfunction

    task automatic test_reset();
        int ones;
        rst = 1'b1;
        repeat (3) @(negedge clk50);
        n_cmp++; if (bus.data_to_dt !== 1'b1)   begin n_err++; $display("FAIL reset_data: got %b want 1", bus.data_to_dt); end
        n_cmp++; if (bus.frame_start !== 1'b0)  begin n_err++; $display("FAIL reset_frame_start: got %b want 0", bus.frame_start); end
        n_cmp++; if (bus.locked !== 1'b0)       begin n_err++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
        n_cmp++; if (bus.swap_pending !== 1'b0) begin n_err++; $display("FAIL reset_swap_pending: got %b want 0", bus.swap_pending); end
        n_cmp++; if (bus.frame_err !== 1'b0)    begin n_err++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
        @(negedge clk50);
        rst = 1'b0;
        ones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge bus.c4);
            #1;
            if (bus.data_to_dt === 1'b1) ones++;
        end
        n_cmp++; if (ones !== 40)               begin n_err++; $display("FAIL idle_data_ones: got %0d want 40", ones); end
        n_cmp++; if (bus.locked !== 1'b0)       begin n_err++; $display("FAIL idle_locked: got %b want 0", bus.locked); end
        n_cmp++; if (bus.frame_err !== 1'b0)    begin n_err++; $display("FAIL idle_frame_err: got %b want 0", bus.frame_err); end
    endtask

    task automatic test_swap();
        int fs0;
        logic [15:0] first16;
        fs0 = fs_cnt;
        send_frame(1'b1, 1, 511);   // frame A: lock, load shadow, request swap
        n_cmp++; if (bus.swap_pending !== 1'b1) begin n_err++; $display("FAIL swap_pending_set: got %b want 1", bus.swap_pending); end
        n_cmp++; if (fs_cnt !== fs0 + 1)        begin n_err++; $display("FAIL frame_start_count_a: got %0d want %0d", fs_cnt, fs0 + 1); end
        send_frame(1'b1, 0, 511);   // frame B: swapped bank on air
        for (int i = 0; i < 16; i++) first16[15-i] = cap[i];
        n_cmp++; if (snap_pend !== 1'b0)        begin n_err++; $display("FAIL swap_pending_clear: got %b want 0", snap_pend); end
        n_cmp++; if (fs_cnt !== fs0 + 2)        begin n_err++; $display("FAIL frame_start_count_b: got %0d want %0d", fs_cnt, fs0 + 2); end
        n_cmp++; if (first16 !== 16'hC003)      begin n_err++; $display("FAIL ch0_bit_periods: got %h want c003", first16); end
        n_cmp++; if (get_byte(0) !== 8'h81)     begin n_err++; $display("FAIL swap_ch0: got %h want 81", get_byte(0)); end
        n_cmp++; if (get_byte(31) !== 8'h3C)    begin n_err++; $display("FAIL swap_ch31: got %h want 3c", get_byte(31)); end
        n_cmp++; if (get_byte(5) !== 8'h5A)     begin n_err++; $display("FAIL swap_ch5: got %h want 5a", get_byte(5)); end
    endtask

    task automatic test_shadow_write();
        send_frame(1'b1, 2, 511);   // frame C: write shadow ch5 = FF, no swap
        n_cmp++; if (get_byte(5) !== 8'h5A)     begin n_err++; $display("FAIL shadow_ch5_c: got %h want 5a", get_byte(5)); end
        send_frame(1'b1, 0, 511);   // frame D
        n_cmp++; if (get_byte(5) !== 8'h5A)     begin n_err++; $display("FAIL shadow_ch5_d: got %h want 5a", get_byte(5)); end
        n_cmp++; if (get_byte(0) !== 8'h81)     begin n_err++; $display("FAIL shadow_ch0_d: got %h want 81", get_byte(0)); end
        n_cmp++; if (bus.frame_err !== 1'b0)    begin n_err++; $display("FAIL shadow_frame_err: got %b want 0", bus.frame_err); end
        n_cmp++; if (bus.locked !== 1'b1)       begin n_err++; $display("FAIL shadow_locked: got %b want 1", bus.locked); end
    endtask

    task automatic test_misaligned_f0();
        send_frame(1'b1, 0, 300);   // frame E stops with pos = 300
        n_cmp++; if (bus.frame_err !== 1'b0)    begin n_err++; $display("FAIL misalign_err_before: got %b want 0", bus.frame_err); end
        send_frame(1'b1, 0, 511);   // frame F: f0 lands at pos 300
        n_cmp++; if (bus.frame_err !== 1'b1)    begin n_err++; $display("FAIL misalign_err: got %b want 1", bus.frame_err); end
        n_cmp++; if (snap_locked !== 1'b1)      begin n_err++; $display("FAIL misalign_locked: got %b want 1", snap_locked); end
        n_cmp++; if (cap[0] !== 1'b1)           begin n_err++; $display("FAIL misalign_first_bit: got %b want 1", cap[0]); end
        n_cmp++; if (get_byte(0) !== 8'h81)     begin n_err++; $display("FAIL misalign_ch0: got %h want 81", get_byte(0)); end
        n_cmp++; if (get_byte(31) !== 8'h3C)    begin n_err++; $display("FAIL misalign_ch31: got %h want 3c", get_byte(31)); end
    endtask

    task automatic test_reset_midframe();
        send_frame(1'b1, 0, 200);   // frame G, interrupted
        @(negedge clk50);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.data_to_dt !== 1'b1)   begin n_err++; $display("FAIL midrst_data: got %b want 1", bus.data_to_dt); end
        n_cmp++; if (bus.locked !== 1'b0)       begin n_err++; $display("FAIL midrst_locked: got %b want 0", bus.locked); end
        n_cmp++; if (bus.frame_err !== 1'b0)    begin n_err++; $display("FAIL midrst_frame_err: got %b want 0", bus.frame_err); end
        repeat (3) @(negedge clk50);
        rst = 1'b0;
        send_frame(1'b1, 0, 511);   // frame H: relock, bank 0 active again
        n_cmp++; if (snap_locked !== 1'b1)      begin n_err++; $display("FAIL relock_locked: got %b want 1", snap_locked); end
        n_cmp++; if (bus.frame_err !== 1'b0)    begin n_err++; $display("FAIL relock_frame_err: got %b want 0", bus.frame_err); end
        n_cmp++; if (bus.swap_pending !== 1'b0) begin n_err++; $display("FAIL relock_swap_pending: got %b want 0", bus.swap_pending); end
        n_cmp++; if (get_byte(5) !== 8'hFF)     begin n_err++; $display("FAIL relock_ch5: got %h want ff", get_byte(5)); end
    endtask

    task automatic test_missing_f0();
        int zeros;
        send_frame(1'b0, 0, 511);   // frame I: no f0
        zeros = 0;
        for (int i = 0; i < 511; i++) if (cap[i] !== 1'b1) zeros++;
        n_cmp++; if (zeros !== 0)               begin n_err++; $display("FAIL missing_idle_bits: got %0d non-one want 0", zeros); end
        n_cmp++; if (snap_locked !== 1'b0)      begin n_err++; $display("FAIL missing_locked: got %b want 0", snap_locked); end
        n_cmp++; if (bus.frame_err !== 1'b1)    begin n_err++; $display("FAIL missing_frame_err: got %b want 1", bus.frame_err); end
        send_frame(1'b1, 0, 511);   // frame J: relock
        n_cmp++; if (snap_locked !== 1'b1)      begin n_err++; $display("FAIL missing_relock: got %b want 1", snap_locked); end
        n_cmp++; if (get_byte(5) !== 8'hFF)     begin n_err++; $display("FAIL missing_relock_ch5: got %h want ff", get_byte(5)); end
    endtask

`ifdef STBUS_TX_PATTERN_EN
    task automatic test_pattern();
        bus.pattern_mode = 1'b1;
        send_frame(1'b1, 0, 511);
        n_cmp++; if (get_byte(0) !== 8'hA5)     begin n_err++; $display("FAIL pattern_ch0: got %h want a5", get_byte(0)); end
        n_cmp++; if (get_byte(1) !== 8'hA4)     begin n_err++; $display("FAIL pattern_ch1: got %h want a4", get_byte(1)); end
        n_cmp++; if (get_byte(31) !== 8'hBA)    begin n_err++; $display("FAIL pattern_ch31: got %h want ba", get_byte(31)); end
        bus.pattern_mode = 1'b0;
    endtask
`endif

    initial begin
        bus.f0       = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.swap_req = 1'b0;
`ifdef STBUS_TX_PATTERN_EN
        bus.pattern_mode = 1'b0;
`endif
        test_reset();
        test_swap();
        test_shadow_write();
        test_misaligned_f0();
        test_reset_midframe();
        test_missing_f0();
`ifdef STBUS_TX_PATTERN_EN
        test_pattern();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stbus_frame_tx.md
# stbus_frame_tx

ST-bus serial transmitter toward the DT side, the counterpart of the frame receiver that deserializes DT/STM data. It runs entirely on clk50, recovers frame timing from the external c4 (4.096 MHz) and active-low f0 frame pulse, and shifts out one 256-bit frame (32 channels × 8 bits, MSB first) per f0 on data_to_dt. Channel bytes come from a host-loaded, double-buffered 32×8 channel store that swaps only on frame boundaries.

## Interface
- CH_NUM, 32, channels per frame; fixed at 32, channel address is 5 bits.
- SYNC_STAGES, 2, synchronizer flops on c4 and f0 (legal values 2 or 3).
- clk50  in  1  system clock, 50 MHz; only clock of the block.
- reset_out_rg  in  1  asynchronous, active-high reset.
- c4  in  1  ST-bus bit clock, asynchronous to clk50.
- f0  in  1  ST-bus frame pulse, active low, asynchronous to clk50.
- wr_en  in  1  host write strobe, one clk50 cycle per byte.
- wr_addr  in  5  channel number for the write.
- wr_data  in  8  channel byte.
- swap_req  in  1  single-cycle pulse: commit shadow bank at next frame start.
- data_to_dt  out  1  serial ST-bus data.
- frame_start  out  1  one-cycle pulse when a frame boundary is taken.
- locked  out  1  frame timing acquired.
- swap_pending  out  1  swap requested, not yet applied.
- frame_err  out  1  sticky: f0 seen at wrong position or missing; cleared by reset only.

## Operation
- c4 and f0 pass through SYNC_STAGES flops; one further register gives c4_rise / c4_fall single-cycle strobes.
- Position counter pos[8:0] counts c4 rises within a frame. On c4_rise with synced f0 low: pos <= 0, frame_start pulses, locked <= 1. Otherwise on c4_rise: pos <= pos + 1 (wraps 511 -> 0).
- Expected f0 position: at rise where pos == 511. If f0 low at any other pos while locked, or pos wraps 511 -> 0 with no f0 while locked: frame_err <= 1; f0 still re-aligns pos to 0; missing f0 clears locked (re-lock on next f0).
- Bit mapping: channel = pos[8:4], bit = 7 - pos[3:1]; each bit spans 2 c4 periods.
- On c4_fall while locked: data_to_dt <= active_bank[channel][bit]. While not locked: data_to_dt held 1 (ST-bus idle).
- Two 32×8 banks; bank_sel register selects active. Host writes always go to the inactive (shadow) bank. Write during frame does not affect current frame.
- swap_req sets swap_pending. On frame_start with swap_pending: bank_sel toggles, swap_pending <= 0, same cycle; first bit of that frame comes from the new bank. swap_req coinciding with frame_start: pending is set, swap takes effect on the following frame.
- Banks are not reset; contents undefined until written.

## Timing
- Reset values: data_to_dt 1, frame_start 0, locked 0, swap_pending 0, frame_err 0, pos 0, bank_sel 0.
- c4 edge to strobe: SYNC_STAGES + 1 clk50 cycles; data_to_dt updates one cycle after c4_fall strobe (4 cycles total with SYNC_STAGES = 2).
- frame_start asserted the cycle after the c4_rise strobe that samples f0 low.
- Reset mid-frame: all state returns to reset values immediately; transmission resumes only after next f0.
- c4 period ≈ 12.2 clk50 cycles; c4_rise and c4_fall never coincide in one cycle.

## Configuration
- STBUS_TX_PATTERN_EN defined: extra input pattern_mode (1 bit) present; when 1, every channel transmits its own channel number XOR 0xA5 instead of bank data (bank writes/swaps still operate). Undefined: port absent, bank data always used.

## Test plan
- Reset, c4 running, no f0 -> data_to_dt stays 1, locked 0, frame_err 0.
- Write ch0 = 0x81, ch31 = 0x3C, swap_req, then f0 every 512 c4 rises -> frame 1: idle/undefined bank 0; frame 2: first 16 c4 periods carry 1,0,0,0,0,0,0,1; last channel 0,0,1,1,1,1,0,0; swap_pending clears at frame 2 start.
- Write shadow ch5 = 0xFF mid-frame without swap_req -> transmitted ch5 unchanged for subsequent frames.
- f0 arrives at pos 300 while locked -> frame_err 1, pos re-aligned, next bit is ch0 bit 7.
- f0 omitted for one frame -> frame_err 1, locked 0, data_to_dt 1 until next f0, then locked 1.
- With STBUS_TX_PATTERN_EN, pattern_mode 1 -> ch0 sends 0xA5, ch1 0xA4, ch31 0xBA.
